// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8-style pipeline: datapath width, ALU opcodes,
// execute-stage FSM encoding and the control bundle carried through EX/MEM.
package cpu_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_LSL   = 4'b1000;
  localparam logic [3:0] ALU_LSR   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MUL_DONE = 2'd2
  } ex_state_t;

  typedef struct packed {
    logic b;
    logic bz;
    logic bnz;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ex_ctrl_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle, low XLEN
// bits of the product kept. done pulses in the cycle of the final step.
module seq_multiplier #(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   cnt;
  logic            busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(MUL_CYCLES);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Terminal count: this cycle's edge performs the last step.
  assign done    = busy_q && (cnt == CW'(1));
  assign busy    = busy_q;
  assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// EX stage: inline ALU, iterative MUL, branch target, and the EX/MEM register
// behind a valid/ready handshake with stall and flush.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | accepting instructions; single-cycle ops retire next edge
// ST_MUL_BUSY | multiplier stepping, input blocked
// ST_MUL_DONE | product ready, waiting for memory stage to accept it
module execute_stage #(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int MUL_CYCLES = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     Instruction,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] Data1,
  input  logic [XLEN-1:0] Data2,
  input  logic [XLEN-1:0] SignExtImm,
  input  logic            ALUSrc,
  input  logic [3:0]      ALUOp,
  input  logic            B,
  input  logic            BZ,
  input  logic            BNZ,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemToReg,
  input  logic            RegWrite,
  input  logic            stall_in,
  input  logic            flush,
  output logic            out_valid,
  output logic [31:0]     Instruction_out,
  output logic [XLEN-1:0] branchAddress,
  output logic [XLEN-1:0] Results,
  output logic [XLEN-1:0] Data2_out,
  output logic            zero,
  output logic            B_out,
  output logic            BZ_out,
  output logic            BNZ_out,
  output logic            MemRead_out,
  output logic            MemWrite_out,
  output logic            MemToReg_out,
  output logic            RegWrite_out
);

  import cpu_pkg::*;

  ex_state_t       state, state_nx;
  ex_ctrl_t        ctrl_in, ctrl_out, pend_ctrl;
  logic [XLEN-1:0] op_b, alu_res, br_addr, mul_prod;
  logic [XLEN-1:0] pend_br, pend_d2;
  logic [31:0]     pend_instr;
  logic            is_mul, transfer, mul_start, load_alu, load_mul;
  logic            mul_busy, mul_done;

  assign ctrl_in = {B, BZ, BNZ, MemRead, MemWrite, MemToReg, RegWrite};
  assign op_b    = ALUSrc ? SignExtImm : Data2;
  assign br_addr = PC + (SignExtImm << 2);
  assign is_mul  = (ALUOp == ALU_MUL);

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      ALU_AND:   alu_res = Data1 & op_b;
      ALU_ORR:   alu_res = Data1 | op_b;
      ALU_ADD:   alu_res = Data1 + op_b;
      ALU_SUB:   alu_res = Data1 - op_b;
      ALU_PASSB: alu_res = op_b;
      ALU_NOR:   alu_res = ~(Data1 | op_b);
      ALU_LSL:   alu_res = Data1 << Instruction[15:10];
      ALU_LSR:   alu_res = Data1 >> Instruction[15:10];
      default:   alu_res = '0;
    endcase
  end

  seq_multiplier #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (flush),
    .a       (Data1),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (mul_start) state_nx = ST_MUL_BUSY;
        ST_MUL_BUSY: if (mul_done) state_nx = ST_MUL_DONE;
        ST_MUL_DONE: if (!stall_in) state_nx = ST_IDLE;
        default:     state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    transfer  = 1'b0;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    in_ready  = (state == ST_IDLE) && !mul_busy && !stall_in && !flush;
    transfer  = in_valid && in_ready;
    mul_start = transfer && is_mul;
    load_alu  = transfer && !is_mul;
    load_mul  = (state == ST_MUL_DONE) && !stall_in && !flush;
  end

  // MUL sideband is captured at accept; operands live inside the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_instr <= '0;
      pend_br    <= '0;
      pend_d2    <= '0;
      pend_ctrl  <= '0;
    end else if (mul_start) begin
      pend_instr <= Instruction;
      pend_br    <= br_addr;
      pend_d2    <= Data2;
      pend_ctrl  <= ctrl_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      Instruction_out <= '0;
      branchAddress   <= '0;
      Results         <= '0;
      Data2_out       <= '0;
      zero            <= 1'b0;
      ctrl_out        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall_in) begin
      out_valid <= load_alu || load_mul;
      if (load_alu) begin
        Instruction_out <= Instruction;
        branchAddress   <= br_addr;
        Results         <= alu_res;
        Data2_out       <= Data2;
        zero            <= (alu_res == '0);
        ctrl_out        <= ctrl_in;
      end else if (load_mul) begin
        Instruction_out <= pend_instr;
        branchAddress   <= pend_br;
        Results         <= mul_prod;
        Data2_out       <= pend_d2;
        zero            <= (mul_prod == '0);
        ctrl_out        <= pend_ctrl;
      end
    end
  end

  assign {B_out, BZ_out, BNZ_out, MemRead_out, MemWrite_out, MemToReg_out, RegWrite_out} = ctrl_out;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized bench for execute_stage, checked against an
// arithmetic reference of the ALU and the EX/MEM timing rules.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Instruction;
  logic [63:0] PC, Data1, Data2, SignExtImm;
  logic        ALUSrc;
  logic [3:0]  ALUOp;
  logic        B, BZ, BNZ, MemRead, MemWrite, MemToReg, RegWrite;
  logic        stall_in, flush;
  logic        out_valid;
  logic [31:0] Instruction_out;
  logic [63:0] branchAddress, Results, Data2_out;
  logic        zero;
  logic        B_out, BZ_out, BNZ_out, MemRead_out, MemWrite_out, MemToReg_out, RegWrite_out;

  logic [6:0]  ctrl_drv;
  logic [6:0]  ctrl_obs;
  assign {B, BZ, BNZ, MemRead, MemWrite, MemToReg, RegWrite} = ctrl_drv;
  assign ctrl_obs = {B_out, BZ_out, BNZ_out, MemRead_out, MemWrite_out, MemToReg_out, RegWrite_out};

  int tests_run;
  int failed;

  logic        e_valid;
  logic [63:0] e_res, e_br, e_d2;
  logic        e_zero;
  logic [31:0] e_instr;
  logic [6:0]  e_ctrl;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Instruction(Instruction), .PC(PC), .Data1(Data1), .Data2(Data2),
    .SignExtImm(SignExtImm), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .B(B), .BZ(BZ), .BNZ(BNZ), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .stall_in(stall_in), .flush(flush),
    .out_valid(out_valid), .Instruction_out(Instruction_out),
    .branchAddress(branchAddress), .Results(Results), .Data2_out(Data2_out),
    .zero(zero), .B_out(B_out), .BZ_out(BZ_out), .BNZ_out(BNZ_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: shifts expressed as multiply/divide by powers of two.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input int sh);
    logic [63:0] p2;
    p2 = 64'd1 << sh;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a + (~b) + 64'd1;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      4'b1000: return a * p2;
      4'b1001: return a / p2;
      4'b1010: return a * b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    in_valid = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] d2,
                       input logic [63:0] imm, input logic [63:0] pc, input logic src,
                       input logic [31:0] instr, input logic [6:0] ctrl);
    logic [63:0] bv;
    in_valid = 1'b1; ALUOp = op; Data1 = a; Data2 = d2; SignExtImm = imm;
    PC = pc; ALUSrc = src; Instruction = instr; ctrl_drv = ctrl;
    bv      = src ? imm : d2;
    e_res   = model(op, a, bv, int'(instr[15:10]));
    e_zero  = (e_res == 64'd0);
    e_br    = pc + imm * 64'd4;
    e_instr = instr;
    e_d2    = d2;
    e_ctrl  = ctrl;
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
    if (e_valid) begin
      chk({tag, ".Results"}, Results, e_res);
      chk({tag, ".zero"}, 64'(zero), 64'(e_zero));
      chk({tag, ".branchAddress"}, branchAddress, e_br);
      chk({tag, ".Instruction_out"}, 64'(Instruction_out), 64'(e_instr));
      chk({tag, ".Data2_out"}, Data2_out, e_d2);
      chk({tag, ".ctrl"}, 64'(ctrl_obs), 64'(e_ctrl));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".Results"}, Results, 64'd0);
    chk({tag, ".branchAddress"}, branchAddress, 64'd0);
    chk({tag, ".Instruction_out"}, 64'(Instruction_out), 64'd0);
    chk({tag, ".Data2_out"}, Data2_out, 64'd0);
    chk({tag, ".zero"}, 64'(zero), 64'd0);
    chk({tag, ".ctrl"}, 64'(ctrl_obs), 64'd0);
  endtask

  // Accept a MUL and follow it to retirement, measuring latency from accept.
  task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b);
    int lat, ready_hits;
    drive(4'b1010, a, b, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0,
          $urandom, 7'($urandom));
    tick();
    set_idle();
    e_valid = 1'b0;
    chk({tag, ".bubble"}, 64'(out_valid), 64'd0);
    lat = 0;
    ready_hits = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_hits++;
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd65);
    chk({tag, ".in_ready_low"}, 64'(ready_hits), 64'd0);
    e_valid = 1'b1;
    check_out(tag);
    tick();
    e_valid = 1'b0;
    check_out({tag, ".after"});
  endtask

  initial begin
    logic [3:0] ops [10];
    int vcount;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1100, 4'b1000, 4'b1001, 4'b0011, 4'b1111};
    tests_run = 0;
    failed    = 0;
    in_valid = 0; Instruction = 0; PC = 0; Data1 = 0; Data2 = 0; SignExtImm = 0;
    ALUSrc = 0; ALUOp = 0; ctrl_drv = 0; stall_in = 0; flush = 0;
    rst_n = 1'b0;

    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset.in_ready", 64'(in_ready), 64'd1);

    // ADD 5 + 7
    drive(4'b0010, 64'd5, 64'd7, 64'd0, 64'h40, 1'b0, 32'h8B07_0000, 7'b0000001);
    tick(); set_idle();
    e_valid = 1'b1;
    check_out("add");
    chk("add.lit", Results, 64'd12);
    tick();
    e_valid = 1'b0;
    check_out("add.idle");

    // CBZ path
    drive(4'b0111, 64'h1234, 64'd0, 64'd4, 64'h100, 1'b0, 32'hB400_0080, 7'b0100000);
    tick(); set_idle();
    e_valid = 1'b1;
    check_out("cbz");
    chk("cbz.br_lit", branchAddress, 64'h110);
    chk("cbz.zero_lit", 64'(zero), 64'd1);

    // randomized single-cycle ops, back to back with occasional gaps
    for (int i = 0; i < 40; i++) begin
      logic [63:0] d2r;
      d2r = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      drive(ops[$urandom_range(0, 9)], {$urandom, $urandom}, d2r, {$urandom, $urandom},
            {$urandom, $urandom}, 1'($urandom), $urandom, 7'($urandom));
      #1 chk("rand.in_ready", 64'(in_ready), 64'd1);
      tick();
      e_valid = 1'b1;
      check_out("rand");
      if (i % 5 == 4) begin
        set_idle();
        tick();
        e_valid = 1'b0;
        check_out("rand.gap");
      end
    end
    set_idle();

    // stall holds the EX/MEM register; flush under stall still clears out_valid
    drive(4'b0010, 64'd10, 64'd20, 64'd3, 64'h200, 1'b0, 32'h8B00_0000, 7'b0000011);
    tick();
    e_valid = 1'b1;
    check_out("stall.load");
    stall_in = 1'b1;
    Data1 = 64'd99; ALUOp = 4'b0110;
    #1 chk("stall.in_ready", 64'(in_ready), 64'd0);
    tick();
    check_out("stall.hold1");
    tick();
    check_out("stall.hold2");
    flush = 1'b1;
    tick();
    e_valid = 1'b0;
    chk("stall.flush", 64'(out_valid), 64'd0);
    flush = 1'b0; stall_in = 1'b0; set_idle();
    tick();
    chk("stall.dropped", 64'(out_valid), 64'd0);

    // flush drops a same-cycle instruction
    drive(4'b0010, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 32'd0, 7'd0);
    flush = 1'b1;
    #1 chk("flush.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("flush.valid", 64'(out_valid), 64'd0);
    flush = 1'b0; set_idle();
    tick();
    chk("flush.dropped", 64'(out_valid), 64'd0);

    // MUL: directed, then random operands including a zero product
    run_mul("mul", 64'hFFFF_FFFF, 64'h10);
    chk("mul.lit", e_res, 64'hF_FFFF_FFF0);
    run_mul("mul.rand1", {$urandom, $urandom}, {$urandom, $urandom});
    run_mul("mul.rand2", {$urandom, $urandom}, 64'($urandom));
    run_mul("mul.zero", {$urandom, $urandom}, 64'd0);

    // MUL reaching MUL_DONE under stall
    drive(4'b1010, 64'd123456789, 64'd987654321, 64'd8, 64'h300, 1'b0, $urandom, 7'b0000001);
    tick(); set_idle();
    repeat (60) tick();
    stall_in = 1'b1;
    repeat (10) tick();
    chk("mulstall.valid_held", 64'(out_valid), 64'd0);
    chk("mulstall.in_ready", 64'(in_ready), 64'd0);
    stall_in = 1'b0;
    tick();
    e_valid = 1'b1;
    check_out("mulstall.load");
    tick();
    chk("mulstall.ready_after", 64'(in_ready), 64'd1);

    // flush at cycle 30 of a MUL
    drive(4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 64'd0, 1'b0, 32'd0, 7'd1);
    tick(); set_idle();
    repeat (30) tick();
    flush = 1'b1;
    #1 chk("mulflush.in_ready_low", 64'(in_ready), 64'd0);
    tick();
    chk("mulflush.valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    #1 chk("mulflush.in_ready", 64'(in_ready), 64'd1);
    drive(4'b0010, 64'd1, 64'd1, 64'd0, 64'h500, 1'b0, 32'h8B01_0000, 7'd1);
    tick(); set_idle();
    e_valid = 1'b1;
    check_out("mulflush.add");
    chk("mulflush.add_lit", Results, 64'd2);
    vcount = 0;
    repeat (50) begin
      tick();
      if (out_valid) vcount++;
    end
    chk("mulflush.no_product", 64'(vcount), 64'd0);

    // async reset mid-MUL
    drive(4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 64'd5, 64'h600, 1'b0, $urandom, 7'h7F);
    tick(); set_idle();
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1 check_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    repeat (70) begin
      tick();
      if (out_valid) vcount++;
    end
    chk("arst.no_product", 64'(vcount), 64'd0);
    drive(4'b0110, 64'd3, 64'd5, 64'd0, 64'h700, 1'b0, 32'hCB00_0000, 7'd1);
    tick(); set_idle();
    e_valid = 1'b1;
    check_out("arst.sub");
    chk("arst.sub_lit", Results, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
